video_vga_dbl: RTL and testbench

- Scan doubler feeding the VGA path of the video output stage.
- Captures each TV-rate line of 8-bit pixel indices (plex) into one half of a ping-pong line buffer while the other half is read out twice at double pixel rate.
- Produces vgaplex and vga_line for the palette/CRAM stage, so a 15 kHz raster becomes a 31 kHz raster.

---
 rtl/video_vga_dbl.sv | 101 ++++++++++
 tb/tb_video_vga_dbl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/video_vga_dbl.sv
// Scan doubler: captures one TV-rate line of pixel indices into a ping-pong
// buffer while the other half is replayed twice at the VGA pixel rate.
module video_vga_dbl #(
    parameter int LINE_LEN = 448,
    parameter int AW       = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c3,
    input  logic       f0,
    input  logic       tv_line_start,
    input  logic       vga_line_start,
    input  logic [7:0] vplex_in,
    output logic [7:0] vgaplex,
    output logic       vga_line
);

    localparam logic [AW:0] LEN = (AW+1)'(LINE_LEN);

    if (LINE_LEN > (1 << AW)) begin : g_len_check
        $error("video_vga_dbl: LINE_LEN larger than one buffer bank");
    end

    logic [7:0]  mem [0:(2**(AW+1))-1];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wbank;
    logic        rbank;
    logic [7:0]  rd_data;
    logic        s1_valid;
    logic        s1_blank;

    logic        wbank_nxt;
    logic        rbank_nxt;
    logic [AW:0] wr_addr;
    logic [AW:0] rd_addr;
    logic        wr_en;
    logic        rd_en;
    logic        rd_active;

    // Line-start pulses act in the same cycle as a coincident strobe, so the
    // effective bank/address are resolved before the RAM access.
    always_comb begin
        wbank_nxt = wbank;
        rbank_nxt = rbank;
        wr_addr   = wr_ptr;
        rd_addr   = rd_ptr;
        if (tv_line_start) begin
            wbank_nxt = ~wbank;
            wr_addr   = '0;
        end
        if (vga_line_start) begin
            rd_addr = '0;
            if (vga_line)
                rbank_nxt = ~wbank_nxt;
        end
        rd_active = (rd_addr < LEN);
        wr_en     = c3 && (wr_addr < LEN) && !rst;
        rd_en     = f0 && rd_active && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= LEN;
            rd_ptr   <= LEN;
            wbank    <= 1'b0;
            rbank    <= 1'b1;
            vga_line <= 1'b1;
            vgaplex  <= 8'h00;
            s1_valid <= 1'b0;
            s1_blank <= 1'b0;
        end else begin
            wbank <= wbank_nxt;
            rbank <= rbank_nxt;
            if (wr_en)
                wr_ptr <= wr_addr + 1'b1;
            else if (tv_line_start)
                wr_ptr <= '0;
            if (rd_en)
                rd_ptr <= rd_addr + 1'b1;
            else if (vga_line_start)
                rd_ptr <= '0;
            if (vga_line_start)
                vga_line <= ~vga_line;
            s1_valid <= f0;
            s1_blank <= !rd_active;
            // Output stage: a strobe past the end of the line yields the blank index.
            if (s1_valid)
                vgaplex <= s1_blank ? 8'h00 : rd_data;
        end
    end

    // Dual-port line RAM; a same-address read returns the data before the write.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wbank_nxt, wr_addr[AW-1:0]}] <= vplex_in;
        if (rd_en)
            rd_data <= mem[{rbank_nxt, rd_addr[AW-1:0]}];
    end

endmodule

// File: tb/tb_video_vga_dbl.sv
// Directed self-checking bench for the video_vga_dbl scan doubler.
module tb_video_vga_dbl;

    localparam int LINE_LEN = 448;

    logic       clk = 1'b0;
    logic       rst;
    logic       c3;
    logic       f0;
    logic       tv_line_start;
    logic       vga_line_start;
    logic [7:0] vplex_in;
    logic [7:0] vgaplex;
    logic       vga_line;

    int checks = 0;
    int errors = 0;

    logic [7:0] wrData [512];
    logic [7:0] rdData [512];

    video_vga_dbl #(.LINE_LEN(LINE_LEN), .AW(9)) dut (
        .clk            (clk),
        .rst            (rst),
        .c3             (c3),
        .f0             (f0),
        .tv_line_start  (tv_line_start),
        .vga_line_start (vga_line_start),
        .vplex_in       (vplex_in),
        .vgaplex        (vgaplex),
        .vga_line       (vga_line)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Captures n pixels from wrData; coincide puts the first c3 on the tv_line_start cycle.
    task automatic applyStimulus(input int n, input bit coincide);
        int offs = coincide ? 0 : 1;
        int last = offs + (n - 1) * 4;
        for (int c = 0; c <= last; c++) begin
            tv_line_start = (c == 0);
            c3            = (c >= offs) && ((c - offs) % 4 == 0);
            vplex_in      = c3 ? wrData[(c - offs) / 4] : 8'h00;
            tick();
        end
        tv_line_start = 1'b0;
        c3            = 1'b0;
    endtask

    // One VGA pass of n f0 strobes (first strobe with vga_line_start), checked against rdData.
    task automatic readPass(input string tag, input int n, input bit expLine,
                            input bit tvStart, input int period);
        int last = (n - 1) * period + 1;
        for (int c = 0; c <= last; c++) begin
            vga_line_start = (c == 0);
            if (tvStart)
                tv_line_start = (c == 0);
            f0 = (c % period == 0) && (c / period < n);
            tick();
            if (c == 0)
                checkOutput({tag, "_vga_line"}, {7'b0, vga_line}, {7'b0, expLine});
            if ((c % period == 1) && (c / period < n))
                checkOutput($sformatf("%s[%0d]", tag, c / period), vgaplex,
                            (c / period < LINE_LEN) ? rdData[c / period] : 8'h00);
        end
        vga_line_start = 1'b0;
        f0             = 1'b0;
        if (tvStart)
            tv_line_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; c3 = 1'b0; f0 = 1'b0;
        tv_line_start = 1'b0; vga_line_start = 1'b0; vplex_in = 8'h00;
        repeat (3) tick();
        checkOutput("reset_vgaplex", vgaplex, 8'h00);
        checkOutput("reset_vga_line", {7'b0, vga_line}, 8'h01);
        rst = 1'b0;
        tick();

        // Ramp line replayed twice
        for (int i = 0; i < 512; i++) begin
            wrData[i] = 8'(i);
            rdData[i] = 8'(i);
        end
        applyStimulus(LINE_LEN, 1'b0);
        readPass("ramp_p1", LINE_LEN, 1'b0, 1'b1, 2);
        readPass("ramp_p2", LINE_LEN, 1'b1, 1'b0, 2);

        // Overflowing capture: only the first LINE_LEN pixels land, then blank
        for (int i = 0; i < 512; i++) begin
            wrData[i] = (i < LINE_LEN) ? 8'hAA : 8'h55;
            rdData[i] = 8'hAA;
        end
        applyStimulus(500, 1'b0);
        readPass("ovf_p1", 500, 1'b0, 1'b1, 2);
        readPass("ovf_p2", 500, 1'b1, 1'b0, 2);

        // tv_line_start coincident with the first c3
        for (int i = 0; i < 512; i++) begin
            wrData[i] = (i == 0) ? 8'h3C : 8'(i) ^ 8'hF0;
            rdData[i] = wrData[i];
        end
        applyStimulus(LINE_LEN, 1'b1);
        readPass("simtv_p1", LINE_LEN, 1'b0, 1'b1, 2);
        readPass("simtv_p2", LINE_LEN, 1'b1, 1'b0, 2);

        // Ping-pong: A then B captured; next line starts midway through A's second pass
        for (int i = 0; i < 512; i++) wrData[i] = 8'h11;
        applyStimulus(LINE_LEN, 1'b0);
        for (int i = 0; i < 512; i++) wrData[i] = 8'h22;
        applyStimulus(LINE_LEN, 1'b0);
        for (int i = 0; i < 512; i++) rdData[i] = 8'h11;
        readPass("pp_a1", LINE_LEN, 1'b0, 1'b0, 2);
        fork
            readPass("pp_a2", LINE_LEN, 1'b1, 1'b0, 2);
            begin
                repeat (400) tick();
                for (int i = 0; i < 512; i++) wrData[i] = 8'h33;
                applyStimulus(LINE_LEN, 1'b0);
            end
        join
        for (int i = 0; i < 512; i++) rdData[i] = 8'h22;
        readPass("pp_b1", LINE_LEN, 1'b0, 1'b0, 2);
        readPass("pp_b2", LINE_LEN, 1'b1, 1'b0, 2);

        // c3 and f0 aligned every 4 clk while capturing the next line
        for (int i = 0; i < 512; i++) begin
            wrData[i] = 8'(i) ^ 8'h5A;
            rdData[i] = wrData[i];
        end
        applyStimulus(LINE_LEN, 1'b0);
        for (int i = 0; i < 512; i++) wrData[i] = 8'(i * 3);
        fork
            applyStimulus(LINE_LEN, 1'b1);
            readPass("coinc_x1", LINE_LEN, 1'b0, 1'b0, 4);
        join
        readPass("coinc_x2", LINE_LEN, 1'b1, 1'b0, 2);
        for (int i = 0; i < 512; i++) rdData[i] = 8'(i * 3);
        readPass("coinc_y1", LINE_LEN, 1'b0, 1'b1, 2);
        readPass("coinc_y2", LINE_LEN, 1'b1, 1'b0, 2);

        // Reset around pixel 100 of both capture and replay
        for (int i = 0; i < 512; i++) begin
            wrData[i] = 8'(i + 1);
            rdData[i] = 8'(i + 1);
        end
        applyStimulus(LINE_LEN, 1'b0);
        for (int i = 0; i < 512; i++) wrData[i] = 8'(i) ^ 8'hC0;
        fork
            applyStimulus(100, 1'b0);
            readPass("rst_pre", 100, 1'b0, 1'b0, 2);
        join
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_vgaplex", vgaplex, 8'h00);
        checkOutput("rst_async_vga_line", {7'b0, vga_line}, 8'h01);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 512; i++) begin
            wrData[i] = 8'(i) + 8'h80;
            rdData[i] = wrData[i];
        end
        applyStimulus(LINE_LEN, 1'b0);
        readPass("rst_post_p1", LINE_LEN, 1'b0, 1'b1, 2);
        readPass("rst_post_p2", LINE_LEN, 1'b1, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
